irq_latch: RTL and testbench
============================

IRQ_LATCH -- requirements
Module: irq_latch

Interface
REQ-001 SHALL have parameter N, default 6, number of request lines; SHALL match the downstream priority encoder input width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port irq_in  input  N  raw request lines, level, synchronous to clk.
REQ-005 SHALL have port mask_we  input  1  mask write strobe.
REQ-006 SHALL have port mask_din  input  N  new mask value (1 = line disabled).
REQ-007 SHALL have port ack  input  1  downstream consumed the presented vector.
REQ-008 SHALL have port clr_lost  input  1  clears lost_o.
REQ-009 SHALL have port vec_o  output  N  held request vector feeding the priority encoder.
REQ-010 SHALL have port req_o  output  1  vec_o valid, awaiting ack.
REQ-011 SHALL have port pend_o  output  N  current pending register.
REQ-012 SHALL have port lost_o  output  N  sticky per-line flag: request lost.

Function
REQ-013 SHALL detect rising edges as edge = irq_in & ~irq_prev, where irq_prev is irq_in registered one cycle.
REQ-014 SHALL set pending bit i on edge[i], regardless of mask.
REQ-015 SHALL set lost_o[i] when edge[i] occurs while pending[i] is already 1 and not being cleared in that cycle.
REQ-016 SHALL clear lost_o on clr_lost; a simultaneous set SHALL win.
REQ-017 SHALL load the mask from mask_din on mask_we; the new mask SHALL affect only subsequent snapshots, never the current vec_o.
REQ-018 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-019 In IDLE, if (pending & ~mask) != 0, the block SHALL register held = pending & ~mask, set req_o = 1 and go to HOLD; otherwise it SHALL remain in IDLE.
REQ-020 In HOLD, vec_o SHALL equal held and SHALL stay stable until ack.
REQ-021 In HOLD with ack = 1, the block SHALL:
- set pending to (pending & ~held) | edge;
- set held to 0;
- set req_o to 0;
- go to IDLE.
REQ-022 When an edge arrives on a held bit in the ack cycle, set SHALL win: the bit stays pending and lost_o is not set.
REQ-023 SHALL ignore ack in IDLE.
REQ-024 vec_o SHALL be all zeros in IDLE; req_o and vec_o SHALL be registered outputs.
REQ-025 Latency SHALL be as follows:
- edge sampled at clock edge k sets pending after edge k;
- req_o rises after edge k+1 (two cycles from input rise).
REQ-026 After ack, a new snapshot SHALL NOT occur before the following clock edge; there SHALL be at least one IDLE cycle between HOLD periods.
REQ-027 Unmasked pending bits outside held SHALL remain pending across HOLD and be snapshotted next.

Reset
REQ-028 While rst_n = 0, the block SHALL hold:
- state = IDLE, pending = 0, held = 0, vec_o = 0, req_o = 0, lost_o = 0;
- mask = 0 (all lines enabled);
- irq_prev = all ones, so lines high at reset release produce no edge.
REQ-029 Reset assertion mid-HOLD SHALL immediately drop req_o and discard held and pending; no ack is required afterwards.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE = 0, HOLD = 1) and the default width constant 6.
REQ-031 Edge detection (irq_prev register and edge logic) SHALL be one sub-module, irq_edge, with its own clk/rst_n; the FSM and registers SHALL remain in irq_latch.

Verification
REQ-032 Reset, then irq_in 000000 -> 000100 -> pend_o = 000100 after 1 edge; req_o = 1 and vec_o = 000100 after 2 edges.
REQ-033 In HOLD with vec_o = 000100, raise irq_in[5], then pulse ack -> vec_o = 0 and req_o = 0 for one cycle, then vec_o = 100000 and req_o = 1.
REQ-034 mask = 100000, edge on bit 5 -> pend_o = 100000 and req_o stays 0; write mask = 0 -> req_o = 1 two cycles later with vec_o = 100000.
REQ-035 Bit 1 pending, second rise on bit 1 before ack -> lost_o = 000010; clr_lost -> lost_o = 0.
REQ-036 Rise on held bit 3 in the ack cycle -> pend_o[3] = 1 afterwards, lost_o[3] = 0, next vec_o has bit 3 set.
REQ-037 irq_in = 111111 during reset, then release -> no pending bits; assert rst_n = 0 mid-HOLD -> req_o = 0 and vec_o = 0 asynchronously.

Source files
------------

// File: rtl/irq_latch_pkg.sv
// Shared definitions for the interrupt latch: snapshot FSM encoding and default line count.
// No logic; width and state constants only.
// No flow control of its own.
package irq_latch_pkg;

    localparam int IRQ_N_DEFAULT = 6;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/irq_edge.sv
// Rising-edge detector on level request lines.
// Combinational rise output; history register updates every cycle.
// No backpressure; a rise is reported in the cycle it is seen.
module irq_edge
    import irq_latch_pkg::*;
#(
    parameter int N = IRQ_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    output logic [N-1:0] rise
);

    logic [N-1:0] irq_prev;

    // Reset to all ones so lines already high at reset release look like old news.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '1;
        end else begin
            irq_prev <= irq_in;
        end
    end

    assign rise = irq_in & ~irq_prev;

endmodule

// File: rtl/irq_latch.sv
// Latches request edges into pending bits and presents masked snapshots to the priority encoder.
// Rise -> pend_o after 1 clock, -> req_o/vec_o after 2 clocks.
// vec_o holds until ack; new edges keep accumulating in pending meanwhile.
module irq_latch
    import irq_latch_pkg::*;
#(
    parameter int N = IRQ_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    input  logic         mask_we,
    input  logic [N-1:0] mask_din,
    input  logic         ack,
    input  logic         clr_lost,
    output logic [N-1:0] vec_o,
    output logic         req_o,
    output logic [N-1:0] pend_o,
    output logic [N-1:0] lost_o
);

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] held_q, held_d;
    logic [N-1:0] mask_q;
    logic [N-1:0] lost_q, lost_d;
    logic         req_q, req_d;
    logic [N-1:0] rise;
    logic [N-1:0] clr_vec;
    logic [N-1:0] lost_set;
    logic [N-1:0] avail;

    irq_edge #(.N(N)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .rise   (rise)
    );

    assign avail = pend_q & ~mask_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | rise;
        held_d  = held_q;
        req_d   = req_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (|avail) begin
                    held_d  = avail;
                    req_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    clr_vec = held_q;
                    pend_d  = (pend_q & ~held_q) | rise;
                    held_d  = '0;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A rise on a bit being consumed this cycle re-arms it instead of counting as lost.
        lost_set = rise & pend_q & ~clr_vec;
        lost_d   = (clr_lost ? '0 : lost_q) | lost_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            held_q  <= '0;
            mask_q  <= '0;
            lost_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
            lost_q  <= lost_d;
            req_q   <= req_d;
            if (mask_we) begin
                mask_q <= mask_din;
            end
        end
    end

    assign vec_o  = held_q;
    assign req_o  = req_q;
    assign pend_o = pend_q;
    assign lost_o = lost_q;

endmodule

// File: tb/tb_irq_latch.sv
module tb_irq_latch;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_in;
    logic         mask_we;
    logic [N-1:0] mask_din;
    logic         ack;
    logic         clr_lost;
    logic [N-1:0] vec_o;
    logic         req_o;
    logic [N-1:0] pend_o;
    logic [N-1:0] lost_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] irq;
        logic         we;
        logic [N-1:0] mdin;
        logic         ack;
        logic         clr;
        logic [N-1:0] e_vec;
        logic         e_req;
        logic [N-1:0] e_pend;
        logic [N-1:0] e_lost;
    } vec_t;

    vec_t tbl[$];

    irq_latch #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .ack      (ack),
        .clr_lost (clr_lost),
        .vec_o    (vec_o),
        .req_o    (req_o),
        .pend_o   (pend_o),
        .lost_o   (lost_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] ev, input logic er,
                           input logic [N-1:0] ep, input logic [N-1:0] el);
        chk({tag, " vec_o"},  vec_o, ev);
        chk({tag, " req_o"},  {{(N-1){1'b0}}, req_o}, {{(N-1){1'b0}}, er});
        chk({tag, " pend_o"}, pend_o, ep);
        chk({tag, " lost_o"}, lost_o, el);
    endtask

    task automatic add(input logic [N-1:0] irq, input logic we, input logic [N-1:0] mdin,
                       input logic a, input logic c, input logic [N-1:0] ev, input logic er,
                       input logic [N-1:0] ep, input logic [N-1:0] el);
        vec_t v;
        v.irq = irq; v.we = we; v.mdin = mdin; v.ack = a; v.clr = c;
        v.e_vec = ev; v.e_req = er; v.e_pend = ep; v.e_lost = el;
        tbl.push_back(v);
    endtask

    initial begin
        //  irq        we mdin       ack clr  vec        req pend       lost
        add(6'b000000, 0, 6'b000000, 0, 0,  6'b000000, 0, 6'b000000, 6'b000000); // s0
        add(6'b000100, 0, 6'b000000, 0, 0,  6'b000000, 0, 6'b000100, 6'b000000); // rise bit2
        add(6'b000100, 0, 6'b000000, 0, 0,  6'b000100, 1, 6'b000100, 6'b000000); // snapshot
        add(6'b100100, 0, 6'b000000, 0, 0,  6'b000100, 1, 6'b100100, 6'b000000); // bit5 in HOLD
        add(6'b100100, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b100000, 6'b000000); // ack
        add(6'b100100, 0, 6'b000000, 0, 0,  6'b100000, 1, 6'b100000, 6'b000000); // next snapshot
        add(6'b100100, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b000000, 6'b000000);
        add(6'b100100, 0, 6'b000000, 0, 0,  6'b000000, 0, 6'b000000, 6'b000000);
        add(6'b000000, 1, 6'b100000, 0, 0,  6'b000000, 0, 6'b000000, 6'b000000); // mask bit5
        add(6'b100000, 0, 6'b000000, 0, 0,  6'b000000, 0, 6'b100000, 6'b000000); // masked rise
        add(6'b100000, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b100000, 6'b000000); // ack in IDLE
        add(6'b100000, 1, 6'b000000, 0, 0,  6'b000000, 0, 6'b100000, 6'b000000); // unmask
        add(6'b100000, 0, 6'b000000, 0, 0,  6'b100000, 1, 6'b100000, 6'b000000);
        add(6'b100000, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b000000, 6'b000000);
        add(6'b000010, 0, 6'b000000, 0, 0,  6'b000000, 0, 6'b000010, 6'b000000); // rise bit1
        add(6'b000010, 0, 6'b000000, 0, 0,  6'b000010, 1, 6'b000010, 6'b000000);
        add(6'b000000, 0, 6'b000000, 0, 0,  6'b000010, 1, 6'b000010, 6'b000000);
        add(6'b000010, 0, 6'b000000, 0, 0,  6'b000010, 1, 6'b000010, 6'b000010); // lost
        add(6'b000000, 0, 6'b000000, 0, 1,  6'b000010, 1, 6'b000010, 6'b000000); // clr_lost
        add(6'b000010, 0, 6'b000000, 0, 1,  6'b000010, 1, 6'b000010, 6'b000010); // set beats clr
        add(6'b000010, 0, 6'b000000, 0, 1,  6'b000010, 1, 6'b000010, 6'b000000);
        add(6'b000010, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b000000, 6'b000000);
        add(6'b001000, 0, 6'b000000, 0, 0,  6'b000000, 0, 6'b001000, 6'b000000); // rise bit3
        add(6'b001000, 0, 6'b000000, 0, 0,  6'b001000, 1, 6'b001000, 6'b000000);
        add(6'b000000, 0, 6'b000000, 0, 0,  6'b001000, 1, 6'b001000, 6'b000000);
        add(6'b001000, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b001000, 6'b000000); // rise in ack cycle
        add(6'b001000, 0, 6'b000000, 0, 0,  6'b001000, 1, 6'b001000, 6'b000000);
        add(6'b001000, 0, 6'b000000, 1, 0,  6'b000000, 0, 6'b000000, 6'b000000);

        rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_din = '0; ack = 1'b0; clr_lost = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 6'b000000, 1'b0, 6'b000000, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            irq_in   = tbl[i].irq;
            mask_we  = tbl[i].we;
            mask_din = tbl[i].mdin;
            ack      = tbl[i].ack;
            clr_lost = tbl[i].clr;
            @(posedge clk);
            #1;
            chk_all($sformatf("step%0d", i), tbl[i].e_vec, tbl[i].e_req, tbl[i].e_pend, tbl[i].e_lost);
        end

        // Lines high through reset must not register as rises on release.
        irq_in = 6'b111111; mask_we = 1'b0; ack = 1'b0; clr_lost = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("hi_in_reset", 6'b000000, 1'b0, 6'b000000, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_all("hi_release", 6'b000000, 1'b0, 6'b000000, 6'b000000);
        end
        irq_in = 6'b111110;
        @(posedge clk);
        #1;
        irq_in = 6'b111111;
        @(posedge clk);
        #1;
        chk_all("bit0_pend", 6'b000000, 1'b0, 6'b000001, 6'b000000);
        @(posedge clk);
        #1;
        chk_all("bit0_hold", 6'b000001, 1'b1, 6'b000001, 6'b000000);

        // Reset mid-HOLD, between clock edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 6'b000000, 1'b0, 6'b000000, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 6'b000000, 1'b0, 6'b000000, 6'b000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
